// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 LSB-first UART receiver running on a single system clock.
// The line is sampled at mid-bit using one baud counter. Each byte is handed
// out with a valid/ready handshake. Framing and overrun errors are reported as
// one-cycle pulses.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int BIT_CYCLES  = 2604,
    parameter int HALF_CYCLES = 1302
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_err;
    logic          r_overrun;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    w_shift_next;
    logic          w_stop_ok;
    logic          w_stop_bad;
    logic          w_load;
    logic          w_accept;

    // Two-flop synchronizer for the asynchronous serial line. It resets to 1
    // because the idle line is high.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Register the state, baud counter, bit index and shift register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Compute the next state and detect stop-bit outcomes. The counter is
    // cleared on every transition and held at zero in IDLE and BREAK, so it
    // never wraps while waiting.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok      = 1'b0;
        w_stop_bad     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    if (!r_rx_s) begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = 3'd0;
                    end else begin
                        // Start bit has already gone high: treat it as a glitch
                        // and drop it without reporting an error.
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next              = '0;
                    w_shift_next[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait here until the line is released. A held-low line (break)
                // must not be taken as a new start bit.
                w_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = r_rx_valid & rx_ready;
    // A new byte may load when the output is empty, or when it is being
    // accepted on this same edge.
    assign w_load   = w_stop_ok & (~r_rx_valid | rx_ready);

    // Output holding register with its handshake, and the error pulses.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_stop_ok & ~w_load;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame, using a short bit time (16 cycles per bit).
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int BIT  = 16;
    localparam int HALF = 8;
    localparam int LAT  = HALF + 9 * BIT + 3;

    logic       clk_50M;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] beats[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    int         vcyc_cnt = 0;
    int         stable_viol = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_frame #(.BIT_CYCLES(BIT), .HALF_CYCLES(HALF)) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc++;

    // Passive recorder, sampled on the falling edge.
    always @(negedge clk_50M) begin
        if (rx_valid && rx_ready) beats.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid) vcyc_cnt++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        if (prev_valid && !prev_ready && rx_valid && (rx_data !== prev_data)) stable_viol++;
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
    end

    // Send one frame. The task is called at a negedge and returns at a negedge.
    task automatic tx_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (BIT) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk_50M);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk_50M);
        $display("tx frame data=%h stop=%0b", d, stop_bit);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_50M);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({frame_err, overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b expected 00", {frame_err, overrun}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_50M);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_frame;
        int b0, fe0, ov0, vc0, lat;
        b0 = beats.size(); fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc_cnt;
        tx_byte(8'h41, 1'b1);
        repeat (4) @(negedge clk_50M);
        lat = rise_cyc - fall_cyc;
        n_checks++; if (beats.size() - b0 !== 1) begin n_fail++; $display("FAIL frame_count: got %0d expected 1", beats.size() - b0); end
        else begin
            n_checks++; if (beats[b0] !== 8'h41) begin n_fail++; $display("FAIL frame_data: got %h expected 41", beats[b0]); end
        end
        n_checks++; if (vcyc_cnt - vc0 !== 1) begin n_fail++; $display("FAIL frame_valid_cycles: got %0d expected 1", vcyc_cnt - vc0); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL frame_ferr: got %0d expected 0", fe_cnt - fe0); end
        n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL frame_ovr: got %0d expected 0", ov_cnt - ov0); end
        n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL frame_latency: got %0d expected %0d+/-1", lat, LAT); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b expected 0", busy); end
        $display("test_frame latency=%0d", lat);
    endtask

    task automatic test_back_to_back;
        int b0, fe0, ov0;
        logic [7:0] exp_q[3];
        exp_q[0] = 8'h57; exp_q[1] = 8'h53; exp_q[2] = 8'h44;
        b0 = beats.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 3; i++) tx_byte(exp_q[i], 1'b1);
        repeat (4) @(negedge clk_50M);
        n_checks++; if (beats.size() - b0 !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", beats.size() - b0); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (beats[b0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, beats[b0 + i], exp_q[i]); end
            end
        end
        n_checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin n_fail++; $display("FAIL b2b_errs: got %0d expected 0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
        $display("test_back_to_back done");
    endtask

    task automatic test_glitch;
        int b0, fe0;
        b0 = beats.size(); fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk_50M);
        rx = 1'b1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_during: got %b expected 1", busy); end
        repeat (20) @(negedge clk_50M);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
        n_checks++; if (beats.size() - b0 !== 0) begin n_fail++; $display("FAIL glitch_beats: got %0d expected 0", beats.size() - b0); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - fe0); end
        $display("test_glitch done");
    endtask

    task automatic test_framing;
        int b0, fe0;
        b0 = beats.size(); fe0 = fe_cnt;
        tx_byte(8'h41, 1'b0);
        repeat (40) @(negedge clk_50M);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
        n_checks++; if (beats.size() - b0 !== 0) begin n_fail++; $display("FAIL ferr_beats: got %0d expected 0", beats.size() - b0); end
        rx = 1'b1;
        repeat (8) @(negedge clk_50M);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy: got %b expected 0", busy); end
        tx_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk_50M);
        n_checks++; if (beats.size() - b0 !== 1) begin n_fail++; $display("FAIL ferr_next_count: got %0d expected 1", beats.size() - b0); end
        else begin
            n_checks++; if (beats[b0] !== 8'h44) begin n_fail++; $display("FAIL ferr_next_data: got %h expected 44", beats[b0]); end
        end
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_total: got %0d expected 1", fe_cnt - fe0); end
        $display("test_framing done");
    endtask

    task automatic test_overrun;
        int b0, fe0, ov0;
        b0 = beats.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        rx_ready = 1'b0;
        tx_byte(8'h41, 1'b1);
        tx_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk_50M);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h41) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 41", rx_data); end
        n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL ovr_ferr: got %0d expected 0", fe_cnt - fe0); end
        n_checks++; if (stable_viol !== 0) begin n_fail++; $display("FAIL ovr_data_stable: got %0d changes expected 0", stable_viol); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL errs_together: got %0d expected 0", both_cnt); end
        @(posedge clk_50M); #2;
        rx_ready = 1'b1;
        @(posedge clk_50M); #1;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_drop: got %b expected 0", rx_valid); end
        n_checks++; if (beats.size() - b0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d expected 1", beats.size() - b0); end
        else begin
            n_checks++; if (beats[b0] !== 8'h41) begin n_fail++; $display("FAIL ovr_accept_data: got %h expected 41", beats[b0]); end
        end
        @(negedge clk_50M);
        $display("test_overrun done");
    endtask

    task automatic test_reset_midframe;
        int b0, fe0;
        logic [7:0] d;
        d = 8'h41;
        b0 = beats.size(); fe0 = fe_cnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk_50M);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk_50M);
        end
        rx = d[4];
        repeat (HALF) @(negedge clk_50M);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50M);
        n_checks++; if (beats.size() - b0 !== 0) begin n_fail++; $display("FAIL midrst_partial: got %0d beats expected 0", beats.size() - b0); end
        tx_byte(8'h53, 1'b1);
        repeat (4) @(negedge clk_50M);
        n_checks++; if (beats.size() - b0 !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", beats.size() - b0); end
        else begin
            n_checks++; if (beats[b0] !== 8'h53) begin n_fail++; $display("FAIL midrst_data_after: got %h expected 53", beats[b0]); end
        end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL midrst_ferr: got %0d expected 0", fe_cnt - fe0); end
        $display("test_reset_midframe done");
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        test_reset();
        test_frame();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
